mult_out_buffer: RTL

//  Elastic buffer directly downstream of the multiplier-switch array (mult_gen).
//  - Captures each full product bus (NUM_PES x OUT_DATA_TYPE) on the array's valid pulse.
//  - Presents captured buses to the reduction network under a valid/ready handshake.
//  - The multiplier array has no backpressure input, so this block supplies the slack.
//  - It also raises an early almost-full throttle and a sticky overflow error.

---
 rtl/mult_out_buffer_pkg.sv | 15 +
 rtl/mult_out_buffer_ctrl.sv | 87 ++++++++
 rtl/mult_out_buffer.sv | 62 ++++++
 3 files changed

// File: rtl/mult_out_buffer_pkg.sv
// Shared defaults for the product path between the multiplier array and the
// reduction network.
package mult_out_buffer_pkg;

  localparam int OUT_DATA_TYPE_DEF = 32;
  localparam int NUM_PES_DEF       = 32;
  localparam int DEPTH_DEF         = 4;
  localparam int AF_LEVEL_DEF      = 2;

  // Pointer width for a power-of-two depth, never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mult_out_buffer_ctrl.sv
// Occupancy control for the product buffer: pointers, count, handshake,
// almost-full throttle and sticky overflow flag.
module mult_out_buffer_ctrl
  import mult_out_buffer_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AF_LEVEL = AF_LEVEL_DEF,
  parameter int PTR_W    = ptr_width(DEPTH),
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic             ready_i,
  output logic             wr_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             valid_o,
  output logic             almost_full_o,
  output logic             overflow_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             af_q, af_d;
  logic             ovf_q, ovf_d;
  logic             full_s, rd_s, wr_s, drop_s;

  // A read in the same cycle frees a slot, so a full buffer still accepts.
  always_comb begin
    full_s   = 1'b0;
    rd_s     = 1'b0;
    wr_s     = 1'b0;
    drop_s   = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    full_s   = (count_q == CNT_W'(DEPTH));
    rd_s     = valid_q & ready_i;
    wr_s     = valid_i & (~full_s | rd_s);
    drop_s   = valid_i & full_s & ~rd_s;
    if (wr_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + CNT_W'(wr_s) - CNT_W'(rd_s);
    valid_d = (count_d != '0);
    af_d    = (count_d >= CNT_W'(AF_LEVEL));
    ovf_d   = ovf_q | drop_s;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
    end
  end

  assign wr_o          = wr_s;
  assign wr_ptr_o      = wr_ptr_q;
  assign rd_ptr_o      = rd_ptr_q;
  assign count_o       = count_q;
  assign valid_o       = valid_q;
  assign almost_full_o = af_q;
  assign overflow_o    = ovf_q;

endmodule

// File: rtl/mult_out_buffer.sv
// Elastic first-word-fall-through buffer for full product buses leaving the
// multiplier array, which has no backpressure of its own.
module mult_out_buffer
  import mult_out_buffer_pkg::*;
#(
  parameter int OUT_DATA_TYPE = OUT_DATA_TYPE_DEF,
  parameter int NUM_PES       = NUM_PES_DEF,
  parameter int DEPTH         = DEPTH_DEF,
  parameter int AF_LEVEL      = AF_LEVEL_DEF,
  parameter int BUS_W         = NUM_PES * OUT_DATA_TYPE,
  parameter int CNT_W         = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [BUS_W-1:0] i_data_bus,
  output logic             o_almost_full,
  output logic             o_overflow,
  output logic [CNT_W-1:0] o_count,
  output logic             o_valid,
  output logic [BUS_W-1:0] o_data_bus,
  input  logic             i_ready
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic             wr_s;
  logic [PTR_W-1:0] wr_ptr_s;
  logic [PTR_W-1:0] rd_ptr_s;
  logic             valid_s;
  logic [BUS_W-1:0] mem_q [DEPTH];

  mult_out_buffer_ctrl #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .PTR_W    (PTR_W),
    .CNT_W    (CNT_W)
  ) u_ctrl (
    .clk_i         (CLK),
    .rst_ni        (rst),
    .valid_i       (i_valid),
    .ready_i       (i_ready),
    .wr_o          (wr_s),
    .wr_ptr_o      (wr_ptr_s),
    .rd_ptr_o      (rd_ptr_s),
    .count_o       (o_count),
    .valid_o       (valid_s),
    .almost_full_o (o_almost_full),
    .overflow_o    (o_overflow)
  );

  // Storage is deliberately unreset; the head mux masks stale entries.
  always_ff @(posedge CLK) begin
    if (wr_s) begin
      mem_q[wr_ptr_s] <= i_data_bus;
    end
  end

  assign o_valid    = valid_s;
  assign o_data_bus = valid_s ? mem_q[rd_ptr_s] : '0;

endmodule
